// File: rtl/riscv_mem_pkg.sv
// rtl/riscv_mem_pkg.sv - shared constants and helpers for the data-memory slave
package riscv_mem_pkg;

  localparam logic [31:0] MMIO_BASE_DEFAULT = 32'h1000_0000;

  localparam logic [31:0] OFF_MTIME_LO    = 32'h0000_0000;
  localparam logic [31:0] OFF_MTIME_HI    = 32'h0000_0004;
  localparam logic [31:0] OFF_MTIMECMP_LO = 32'h0000_0008;
  localparam logic [31:0] OFF_MTIMECMP_HI = 32'h0000_000C;
  localparam logic [31:0] OFF_TOHOST      = 32'h0000_0010;

  // Width of the RAM word index; never below one bit so degenerate depths still elaborate.
  function automatic int unsigned word_addr_width(input int unsigned words);
    return (words > 1) ? $clog2(words) : 1;
  endfunction

endpackage

// File: rtl/riscv_mmio_timer.sv
// rtl/riscv_mmio_timer.sv - 64-bit mtime, prescaler, mtimecmp, hi snapshot and irq
module riscv_mmio_timer #(
  parameter int unsigned TICK_DIV = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_lo,
  input  logic        wr_hi,
  input  logic        wr_cmp_lo,
  input  logic        wr_cmp_hi,
  input  logic        snap,
  input  logic [31:0] wdata,
  output logic [63:0] mtime,
  output logic [63:0] mtimecmp,
  output logic [31:0] hi_shadow,
  output logic        irq
);

  localparam int unsigned   PW      = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PS_LAST = PW'(TICK_DIV - 1);

  logic [PW-1:0] pcnt;
  logic          tick;

  assign tick = (pcnt == PS_LAST);

  // Timer state; a store to either mtime half wins over the tick and restarts the prescaler.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mtime     <= '0;
      mtimecmp  <= '1;
      hi_shadow <= '0;
      irq       <= 1'b0;
      pcnt      <= '0;
    end else begin
      irq <= (mtime >= mtimecmp);
      if (snap) hi_shadow <= mtime[63:32];
      if (wr_cmp_lo) mtimecmp[31:0]  <= wdata;
      if (wr_cmp_hi) mtimecmp[63:32] <= wdata;
      if (wr_lo || wr_hi) begin
        pcnt <= '0;
        if (wr_lo) mtime[31:0]  <= wdata;
        if (wr_hi) mtime[63:32] <= wdata;
      end else if (tick) begin
        pcnt  <= '0;
        mtime <= mtime + 64'd1;
      end else begin
        pcnt <= pcnt + PW'(1);
      end
    end
  end

endmodule

// File: rtl/riscv_data_slave.sv
// rtl/riscv_data_slave.sv - single-cycle data port: word RAM, MMIO timer and tohost
module riscv_data_slave
  import riscv_mem_pkg::*;
#(
  parameter int unsigned RAM_WORDS = 1024,
  parameter logic [31:0] MMIO_BASE = MMIO_BASE_DEFAULT,
  parameter int unsigned TICK_DIV  = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        data_ce_i,
  input  logic        data_we_i,
  input  logic [31:0] data_addr_i,
  input  logic [31:0] data_i,
  output logic [31:0] data_o,
  output logic        err_o,
  output logic        timer_irq_o,
  output logic        halt_o,
  output logic [30:0] exit_code_o
);

  localparam int unsigned AW        = word_addr_width(RAM_WORDS);
  localparam logic [31:0] RAM_BYTES = 32'(RAM_WORDS * 4);

  logic [31:0]   ram [RAM_WORDS];
  logic [AW-1:0] ram_idx;
  logic          aligned, in_ram;
  logic          hit_lo, hit_hi, hit_cmp_lo, hit_cmp_hi, hit_tohost;
  logic          fault, load, store;
  logic [63:0]   mtime, mtimecmp;
  logic [31:0]   hi_shadow;

  assign ram_idx    = data_addr_i[AW+1:2];
  assign aligned    = (data_addr_i[1:0] == 2'b00);
  assign in_ram     = (data_addr_i < RAM_BYTES);
  assign hit_lo     = (data_addr_i == MMIO_BASE + OFF_MTIME_LO);
  assign hit_hi     = (data_addr_i == MMIO_BASE + OFF_MTIME_HI);
  assign hit_cmp_lo = (data_addr_i == MMIO_BASE + OFF_MTIMECMP_LO);
  assign hit_cmp_hi = (data_addr_i == MMIO_BASE + OFF_MTIMECMP_HI);
  assign hit_tohost = (data_addr_i == MMIO_BASE + OFF_TOHOST);

  assign fault = data_ce_i && !(aligned &&
                 (in_ram || hit_lo || hit_hi || hit_cmp_lo || hit_cmp_hi || hit_tohost));
  assign load  = data_ce_i && !data_we_i && !fault;
  assign store = data_ce_i &&  data_we_i && !fault;

  riscv_mmio_timer #(.TICK_DIV(TICK_DIV)) u_timer (
    .clk       (clk),
    .rst       (rst),
    .wr_lo     (store && hit_lo),
    .wr_hi     (store && hit_hi),
    .wr_cmp_lo (store && hit_cmp_lo),
    .wr_cmp_hi (store && hit_cmp_hi),
    .snap      (load && hit_lo),
    .wdata     (data_i),
    .mtime     (mtime),
    .mtimecmp  (mtimecmp),
    .hi_shadow (hi_shadow),
    .irq       (timer_irq_o)
  );

  // Zero-latency read mux; anything other than a clean load returns zero.
  always_comb begin
    data_o = '0;
    if (load) begin
      if (in_ram)          data_o = ram[ram_idx];
      else if (hit_lo)     data_o = mtime[31:0];
      else if (hit_hi)     data_o = hi_shadow;
      else if (hit_cmp_lo) data_o = mtimecmp[31:0];
      else if (hit_cmp_hi) data_o = mtimecmp[63:32];
      else if (hit_tohost) data_o = {exit_code_o, halt_o};
    end
  end

  // RAM write port; contents survive reset, but a store on an edge with rst high is dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
    end else if (store && in_ram) begin
      ram[ram_idx] <= data_i;
    end
  end

  // Fault pulse and sticky tohost halt/exit latch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_o       <= 1'b0;
      halt_o      <= 1'b0;
      exit_code_o <= '0;
    end else begin
      err_o <= fault;
      if (store && hit_tohost && data_i[0] && !halt_o) begin
        halt_o      <= 1'b1;
        exit_code_o <= data_i[31:1];
      end
    end
  end

endmodule

// File: tb/tb_riscv_data_slave.sv
// tb/tb_riscv_data_slave.sv - randomized bench against a behavioural memory/timer model
module tb_riscv_data_slave;

  localparam int unsigned RW        = 1024;
  localparam logic [31:0] BASE      = 32'h1000_0000;
  localparam int          TD        = 1;
  localparam logic [31:0] RAM_BYTES = 32'(RW * 4);

  logic        clk = 1'b0;
  logic        rst;
  logic        data_ce_i, data_we_i;
  logic [31:0] data_addr_i, data_i, data_o;
  logic        err_o, timer_irq_o, halt_o;
  logic [30:0] exit_code_o;

  always #5 clk = ~clk;

  riscv_data_slave #(.RAM_WORDS(RW), .MMIO_BASE(BASE), .TICK_DIV(TD)) dut (
    .clk         (clk),
    .rst         (rst),
    .data_ce_i   (data_ce_i),
    .data_we_i   (data_we_i),
    .data_addr_i (data_addr_i),
    .data_i      (data_i),
    .data_o      (data_o),
    .err_o       (err_o),
    .timer_irq_o (timer_irq_o),
    .halt_o      (halt_o),
    .exit_code_o (exit_code_o)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Reference model state
  bit [31:0] m_ram [int];
  bit [63:0] m_mtime, m_cmp;
  bit [31:0] m_shadow;
  bit        m_irq, m_err, m_halt;
  bit [30:0] m_exit;
  int        m_pcnt;

  function automatic void model_reset();
    m_mtime = 64'd0; m_cmp = '1; m_shadow = 32'd0;
    m_irq = 1'b0; m_err = 1'b0; m_halt = 1'b0; m_exit = '0; m_pcnt = 0;
  endfunction

  function automatic bit is_fault(input bit ce, input bit [31:0] a);
    if (!ce) return 1'b0;
    if (a[1:0] != 2'b00) return 1'b1;
    if (a < RAM_BYTES) return 1'b0;
    if (a >= BASE && a <= BASE + 32'h10) return 1'b0;
    return 1'b1;
  endfunction

  function automatic bit [31:0] model_read(input bit [31:0] a);
    if (a < RAM_BYTES) return m_ram.exists(int'(a >> 2)) ? m_ram[int'(a >> 2)] : 32'd0;
    case (a - BASE)
      32'h00:  return m_mtime[31:0];
      32'h04:  return m_shadow;
      32'h08:  return m_cmp[31:0];
      32'h0C:  return m_cmp[63:32];
      default: return {m_exit, m_halt};
    endcase
  endfunction

  // One bus cycle: drive, check outputs mid-cycle, then advance the model across the edge.
  task automatic step(input bit ce, input bit we, input bit [31:0] a, input bit [31:0] d);
    bit        f, wrote_time;
    bit [31:0] exp_d;
    data_ce_i = ce; data_we_i = we; data_addr_i = a; data_i = d;
    f     = is_fault(ce, a);
    exp_d = (ce && !we && !f) ? model_read(a) : 32'd0;
    @(negedge clk);
    check("data_o", {32'd0, data_o}, {32'd0, exp_d});
    check("err_o", {63'd0, err_o}, {63'd0, m_err});
    check("timer_irq_o", {63'd0, timer_irq_o}, {63'd0, m_irq});
    check("halt_o", {63'd0, halt_o}, {63'd0, m_halt});
    check("exit_code_o", {33'd0, exit_code_o}, {33'd0, m_exit});
    @(posedge clk);
    m_err = f;
    m_irq = (m_mtime >= m_cmp);
    wrote_time = 1'b0;
    if (ce && !we && !f && a == BASE) m_shadow = m_mtime[63:32];
    if (ce && we && !f) begin
      if (a < RAM_BYTES) m_ram[int'(a >> 2)] = d;
      else begin
        case (a - BASE)
          32'h00: begin m_mtime[31:0]  = d; wrote_time = 1'b1; end
          32'h04: begin m_mtime[63:32] = d; wrote_time = 1'b1; end
          32'h08: m_cmp[31:0]  = d;
          32'h0C: m_cmp[63:32] = d;
          default: if (d[0] && !m_halt) begin m_halt = 1'b1; m_exit = d[31:1]; end
        endcase
      end
    end
    if (wrote_time) m_pcnt = 0;
    else begin
      m_pcnt++;
      if (m_pcnt == TD) begin m_pcnt = 0; m_mtime = m_mtime + 64'd1; end
    end
    #1;
  endtask

  // Reset asserted between edges while a store to mtimecmp is being presented.
  task automatic reset_mid();
    data_ce_i = 1'b1; data_we_i = 1'b1; data_addr_i = BASE + 32'h08; data_i = 32'd0;
    rst = 1'b1;
    #1;
    check("async_halt", {63'd0, halt_o}, 64'd0);
    check("async_exit", {33'd0, exit_code_o}, 64'd0);
    check("async_irq", {63'd0, timer_irq_o}, 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    int        r;
    bit [31:0] a, d;
    bit        we;
    rst = 1'b1; data_ce_i = 1'b0; data_we_i = 1'b0; data_addr_i = '0; data_i = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_data_o", {32'd0, data_o}, 64'd0);
    check("rst_err", {63'd0, err_o}, 64'd0);
    check("rst_irq", {63'd0, timer_irq_o}, 64'd0);
    check("rst_halt", {63'd0, halt_o}, 64'd0);
    check("rst_exit", {33'd0, exit_code_o}, 64'd0);
    rst = 1'b0;
    model_reset();

    // RAM store/load and ce=0
    step(1, 1, 32'h40, 32'hDEAD_BEEF);
    step(1, 0, 32'h40, 32'h0);
    step(0, 0, 32'h44, 32'h0);
    // Faults: misaligned store, out-of-map load
    step(1, 1, 32'h42, 32'h1234_5678);
    step(1, 0, 32'h40, 32'h0);
    step(1, 0, 32'h2000_0000, 32'h0);
    step(0, 0, 32'h0, 32'h0);
    // Boundaries: last RAM word, first byte past RAM, first offset past MMIO
    step(1, 1, RAM_BYTES - 32'd4, 32'hA5A5_0001);
    step(1, 0, RAM_BYTES - 32'd4, 32'h0);
    step(1, 0, RAM_BYTES, 32'h0);
    step(1, 1, BASE + 32'h14, 32'h1);

    // Timer wrap with hi snapshot
    step(1, 1, BASE + 32'h04, 32'hFFFF_FFFF);
    step(1, 1, BASE, 32'hFFFF_FFFE);
    step(0, 0, 32'h0, 32'h0);
    step(1, 0, BASE, 32'h0);
    step(1, 0, BASE + 32'h04, 32'h0);
    step(1, 0, BASE, 32'h0);
    step(1, 0, BASE + 32'h04, 32'h0);

    // Interrupt rise and clear
    reset_mid();
    step(1, 1, BASE + 32'h0C, 32'h0);
    step(1, 1, BASE + 32'h08, 32'd10);
    repeat (12) step(0, 0, 32'h0, 32'h0);
    check("irq_high", {63'd0, timer_irq_o}, 64'd1);
    step(1, 1, BASE + 32'h08, 32'hFFFF_FFFF);
    repeat (2) step(0, 0, 32'h0, 32'h0);
    check("irq_cleared", {63'd0, timer_irq_o}, 64'd0);

    // Halt, sticky exit code, then reset during stores
    step(1, 1, BASE + 32'h10, 32'h0000_0055);
    step(1, 0, BASE + 32'h10, 32'h0);
    check("exit_2a", {33'd0, exit_code_o}, 64'h2A);
    step(1, 1, BASE + 32'h10, 32'h3);
    step(1, 1, 32'h80, 32'h0BAD_F00D);
    check("exit_sticky", {33'd0, exit_code_o}, 64'h2A);
    reset_mid();
    step(1, 0, BASE + 32'h08, 32'h0);
    step(1, 0, 32'h80, 32'h0);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      if (i == 200) reset_mid();
      r = $urandom_range(0, 99);
      we = 1'($urandom_range(0, 1));
      if (r < 10) begin
        step(0, we, $urandom, $urandom);
      end else if (r < 45) begin
        a = ($urandom_range(0, 7) == 0) ? RAM_BYTES - 32'd4 : 32'($urandom_range(0, 15)) << 2;
        if (we || !m_ram.exists(int'(a >> 2))) step(1, 1, a, $urandom);
        else step(1, 0, a, 32'h0);
      end else if (r < 80) begin
        a = BASE + (32'($urandom_range(0, 4)) << 2);
        case (a - BASE)
          32'h08:  d = m_mtime[31:0] + 32'($urandom_range(0, 12));
          32'h0C:  d = ($urandom_range(0, 3) == 0) ? $urandom : m_mtime[63:32];
          32'h10:  d = {$urandom_range(0, 32'h7FFF_FFFF), 1'($urandom_range(0, 9) == 0)};
          default: d = $urandom;
        endcase
        step(1, we, a, d);
      end else begin
        case ($urandom_range(0, 4))
          0:       a = (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(1, 3));
          1:       a = BASE + 32'h14 + (32'($urandom_range(0, 3)) << 2);
          2:       a = RAM_BYTES + (32'($urandom_range(0, 15)) << 2);
          3:       a = BASE + 32'($urandom_range(1, 3));
          default: a = 32'h2000_0000;
        endcase
        step(1, we, a, $urandom);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
